// File: rtl/izhikevich_state_update.sv
// rtl/izhikevich_state_update.sv - Izhikevich v/w integration, spike detect/reset and refractory hold-off
module izhikevich_state_update #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter logic [N-1:0] V_INIT = N'(-65 * (2 ** Q)),
  parameter logic [N-1:0] W_INIT = N'(-13 * (2 ** Q)),
  parameter logic [N-1:0] V_TH = N'(30 * (2 ** Q)),
  parameter int REFRAC_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     dv,
  input  logic [N-1:0]     dw,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  output logic [N-1:0]     v,
  output logic [N-1:0]     w,
  output logic             spike,
  output logic             out_valid,
  output logic [CNT_W-1:0] spike_count
);

  localparam int RW = $clog2(REFRAC_CYCLES + 2);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REFRAC} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_v_nxt;
  logic [N-1:0]     r_w_nxt;
  logic [N-1:0]     r_v;
  logic [N-1:0]     r_w;
  logic             r_spike;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;
  logic [RW-1:0]    r_refrac_cnt;
  logic             w_accept;
  logic             w_fire;

  // Signed add that clamps to the most positive / most negative code on overflow
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] s;
    s = a + b;
    if ((a[N-1] == b[N-1]) && (s[N-1] != a[N-1]))
      sat_add = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      sat_add = s;
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_fire   = ($signed(r_v_nxt) >= $signed(V_TH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-length refractory period skips REFRAC entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_CHECK;
      S_CHECK:  if (w_fire && (REFRAC_CYCLES > 0)) w_state_nxt = S_REFRAC;
                else w_state_nxt = S_IDLE;
      S_REFRAC: if (r_refrac_cnt == '0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: only IDLE accepts samples
  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  // Datapath: latch sums on accept, commit or spike-reset in CHECK, run refractory counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_nxt      <= '0;
      r_w_nxt      <= '0;
      r_v          <= V_INIT;
      r_w          <= W_INIT;
      r_spike      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_count      <= '0;
      r_refrac_cnt <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_spike     <= 1'b0;
      if ((r_state == S_IDLE) && w_accept) begin
        r_v_nxt <= sat_add(r_v, dv);
        r_w_nxt <= sat_add(r_w, dw);
      end
      if (r_state == S_CHECK) begin
        r_out_valid <= 1'b1;
        if (w_fire) begin
          r_v          <= c;
          r_w          <= sat_add(r_w_nxt, d);
          r_spike      <= 1'b1;
          r_refrac_cnt <= RW'(REFRAC_CYCLES);
          if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
        end else begin
          r_v <= r_v_nxt;
          r_w <= r_w_nxt;
        end
      end
      if ((r_state == S_REFRAC) && (r_refrac_cnt != '0))
        r_refrac_cnt <= r_refrac_cnt - RW'(1);
    end
  end

  assign v           = r_v;
  assign w           = r_w;
  assign spike       = r_spike;
  assign out_valid   = r_out_valid;
  assign spike_count = r_count;

endmodule

// File: tb/tb_izhikevich_state_update.sv
// tb/tb_izhikevich_state_update.sv - directed self-checking bench for izhikevich_state_update
module tb_izhikevich_state_update;

  localparam logic [31:0] VI = 32'hFFBF0000;
  localparam logic [31:0] WI = 32'hFFF30000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dv, dw, c, d;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] v, w;
  logic        spike;
  logic        out_valid;
  logic [15:0] spike_count;

  int n_vec = 0;
  int n_err = 0;

  izhikevich_state_update dut (
    .clk(clk), .rst(rst), .dv(dv), .dw(dw), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .d(d), .v(v), .w(w), .spike(spike), .out_valid(out_valid), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present a sample, wait (bounded) for acceptance, then step to the out_valid cycle
  task automatic send(input string tag, input logic [31:0] dvi, input logic [31:0] dwi);
    int k;
    dv = dvi;
    dw = dwi;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_check_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_check_rdy"}, 32'(in_ready), 32'd0);
    tick();
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ev, input logic [31:0] ew,
                         input logic es, input logic [15:0] ec);
    chk({tag, "_v"}, v, ev);
    chk({tag, "_w"}, w, ew);
    chk({tag, "_spike"}, 32'(spike), 32'(es));
    chk({tag, "_cnt"}, 32'(spike_count), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; dv = '0; dw = '0; c = 32'hFFBF0000; d = 32'h00080000;

    // 1: reset state
    do_reset();
    chk_out("rst", VI, WI, 1'b0, 16'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);

    // 2: no spike
    send("nospk", 32'h00010000, 32'hFFFF8000);
    chk_out("nospk", 32'hFFC00000, 32'hFFF28000, 1'b0, 16'd0);
    chk("nospk_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("nospk_pulse", 32'(out_valid), 32'd0);

    // 3: spike from reset state, refractory ignores in_valid
    do_reset();
    send("spk", 32'h00640000, 32'h0);
    chk_out("spk", 32'hFFBF0000, 32'hFFFB0000, 1'b1, 16'd1);
    chk("spk_rdy0", 32'(in_ready), 32'd0);
    dv = 32'h00640000;
    in_valid = 1'b1;
    tick();
    chk("refrac1_rdy", 32'(in_ready), 32'd0);
    chk("refrac1_ov", 32'(out_valid), 32'd0);
    chk("refrac1_spike", 32'(spike), 32'd0);
    tick();
    chk("refrac2_rdy", 32'(in_ready), 32'd0);
    chk("refrac2_ov", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("refrac_end_rdy", 32'(in_ready), 32'd1);
    chk("refrac_end_ov", 32'(out_valid), 32'd0);

    // 4: threshold edge, v=-65 w=-5 entering
    send("th_below", 32'h005EFFFF, 32'h0);
    chk_out("th_below", 32'h001DFFFF, 32'hFFFB0000, 1'b0, 16'd1);
    send("th_eq", 32'h00000001, 32'h0);
    chk_out("th_eq", 32'hFFBF0000, 32'h00030000, 1'b1, 16'd2);

    // 5: saturation of w
    do_reset();
    send("sat1", 32'h0, 32'h7FFFFFFF);
    chk_out("sat1", VI, 32'h7FF2FFFF, 1'b0, 16'd0);
    send("sat2", 32'h0, 32'h7FFFFFFF);
    chk_out("sat2", VI, 32'h7FFFFFFF, 1'b0, 16'd0);
    send("sat3", 32'h0, 32'h80010001);
    chk("sat3_w", w, 32'h00010000);
    send("sat4", 32'h0, 32'h80000000);
    chk("sat4_w", w, 32'h80010000);
    send("sat5", 32'h0, 32'h80000000);
    chk("sat5_w", w, 32'h80000000);

    // 6a: reset in CHECK discards the sample
    do_reset();
    dv = 32'h00010000; dw = 32'h00010000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("midrst_in_check", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ov", 32'(out_valid), 32'd0);
    chk_out("midrst", VI, WI, 1'b0, 16'd0);
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("midrst_ov_late", 32'(out_valid), 32'd0);
    chk("midrst_v_late", v, VI);

    // 6b: reset during REFRAC aborts the hold-off
    send("rfrst", 32'h00640000, 32'h0);
    chk("rfrst_spike", 32'(spike), 32'd1);
    tick();
    chk("rfrst_in_refrac", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rfrst_rdy", 32'(in_ready), 32'd1);
    chk("rfrst_cnt", 32'(spike_count), 32'd0);
    chk("rfrst_v", v, VI);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
